// File: rtl/truth_table_seq.sv
// Registered N_IN-input truth-table gate with valid/ready flow control.
// Define TT_CFG_EN to build the serial table-load port and LOAD state.
module truth_table_seq #(
  parameter int unsigned N_IN = 3,
  parameter logic [(2**N_IN)-1:0] TT_INIT = 8'h12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done
);

  localparam int unsigned DEPTH = 2**N_IN;

  logic [DEPTH-1:0] w_table;
  logic [N_IN-1:0]  w_idx;
  logic             w_run;
  logic             w_accept;

  // Table MSB holds vector 0, so the bit index is the inverted vector.
  assign w_idx    = ~in_vec;
  assign in_ready = w_run && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef TT_CFG_EN
  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t           r_state;
  logic [DEPTH-1:0] r_table;
  logic [DEPTH-1:0] r_shadow;
  logic [N_IN-1:0]  r_cnt;
  logic             r_done;
  logic [DEPTH-1:0] w_shift;

  assign w_shift  = (r_shadow << 1) | DEPTH'(cfg_bit);
  assign w_table  = r_table;
  assign w_run    = (r_state == ST_RUN);
  assign cfg_busy = (r_state == ST_LOAD);
  assign cfg_done = r_done;

  // Load FSM: the active table is only replaced when the final bit lands.
  always_ff @(posedge clk or posedge rst) begin : p_load
    if (rst) begin
      r_state  <= ST_RUN;
      r_table  <= TT_INIT;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (cfg_start) begin
            r_state  <= ST_LOAD;
            r_shadow <= '0;
            r_cnt    <= '0;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            r_shadow <= '0;
            r_cnt    <= '0;
          end else if (cfg_valid) begin
            r_shadow <= w_shift;
            if (r_cnt == N_IN'(DEPTH - 1)) begin
              r_table <= w_shift;
              r_state <= ST_RUN;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + N_IN'(1);
            end
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end
`else
  logic w_cfg_unused;

  assign w_cfg_unused = cfg_start ^ cfg_valid ^ cfg_bit;
  assign w_table      = TT_INIT;
  assign w_run        = 1'b1;
  assign cfg_busy     = 1'b0;
  assign cfg_done     = 1'b0;
`endif

  // Output register: holds a result until downstream takes it.
  always_ff @(posedge clk or posedge rst) begin : p_out
    if (rst) begin
      out_valid <= 1'b0;
      out       <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out       <= w_table[w_idx];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/truth_table_seq.md
# truth_table_seq

Parametrised, registered truth-table logic gate. It evaluates an N_IN-input Boolean function held in a reloadable truth-table register and returns one result bit per accepted input vector. It sits where fixed 3-input case-statement gates sit today, adding:

- generalised input width,
- valid/ready flow control on both sides,
- a serial truth-table load port, so one instance can be reprogrammed to any function.

## Interface
Parameters:
- N_IN, 3, number of function inputs (1..6); table depth is 2**N_IN.
- TT_INIT, 8'h12, reset truth table, 2**N_IN bits wide. Bit (2**N_IN-1-idx) is the output for input vector idx, so the MSB holds the result for vector 0.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an input vector is presented.
- in_ready  out  1  the block accepts the vector this cycle.
- in_vec  in  N_IN  input vector, {in1,...,inN}; in1 is the MSB.
- out_valid  out  1  a result is held.
- out_ready  in  1  downstream accepts the result.
- out  out  1  function result.
- cfg_start  in  1  pulse that begins a table load.
- cfg_valid  in  1  cfg_bit is valid.
- cfg_bit  in  1  serial table bit, MSB (vector 0) first.
- cfg_busy  out  1  a load is in progress.
- cfg_done  out  1  one-cycle pulse when a load completes.

## Operation
- State machine has two states:
  - RUN (reset state): evaluates inputs.
  - LOAD: shifts in a new table.
- RUN -> LOAD on cfg_start. The bit counter clears; the shadow shift register clears to 0.
- In LOAD, each cycle with cfg_valid=1 shifts cfg_bit into the shadow register LSB (left shift) and increments the counter.
- When the 2**N_IN-th bit is accepted:
  - the shadow register is copied into the active table the same edge;
  - the state returns to RUN;
  - cfg_done pulses high on the following cycle.
- cfg_start while in LOAD restarts the load: counter and shadow register clear, and the active table is unchanged.
- cfg_valid while in RUN with no cfg_start is ignored.
- The active table changes only on load completion. A partial load never disturbs the function.
- Evaluation, in RUN only:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - On in_valid && in_ready, out is set to table[2**N_IN-1-in_vec] and out_valid is set to 1.
- out_valid clears on out_ready when no new vector is accepted the same cycle.
- A held result stays stable (out unchanged) while out_valid=1 and out_ready=0.
- A result already in the output register when LOAD starts is still delivered, with its old-table value.
- cfg_start and an input handshake in the same cycle: the input is accepted with the old table, then the state enters LOAD.

## Timing
- Reset values:
  - state=RUN, table=TT_INIT, shadow=0, counter=0.
  - out_valid=0, out=0.
  - cfg_busy=0, cfg_done=0.
  - in_ready=1 once rst deasserts.
- Latency: a result is visible one cycle after the input handshake. Full throughput is one vector per cycle when out_ready=1.
- cfg_busy is high from the cycle after cfg_start through the cycle of the last bit edge (registered state==LOAD).
- A vector presented the cycle after cfg_done is evaluated with the new table.
- A minimum load takes 2**N_IN+1 cycles from cfg_start to the first new-table acceptance.
- Reset mid-load aborts the load and restores TT_INIT. An in-flight output is discarded (out_valid=0).

## Configuration
- TT_CFG_EN defined: the serial load port and LOAD state are built as described.
- TT_CFG_EN undefined:
  - the table is the constant TT_INIT;
  - cfg_start, cfg_valid and cfg_bit are ignored;
  - cfg_busy and cfg_done are tied 0;
  - state is permanently RUN;
  - the port list is unchanged.

## Test plan
- Reset, N_IN=3, TT_INIT=8'h12, out_ready=1: apply vectors 0..7 back-to-back -> out=1 only for 3'b011 and 3'b110, one result per cycle, each one cycle after acceptance.
- Hold out_ready=0 after vector 3'b011 -> out_valid=1, out=1 stable, in_ready=0. Release -> next queued vector 3'b110 is accepted that cycle.
- Load 8'h80 (bits 1,0,0,0,0,0,0,0) -> cfg_busy high for 8 valid bits, cfg_done pulse. Then vector 3'b000 gives out=1 and 3'b011 gives out=0.
- Load with cfg_valid gaps and a second cfg_start after 4 bits, then 8 bits of 8'h01 -> only 3'b111 gives 1; in_ready=0 throughout LOAD.
- Assert rst after 5 of 8 load bits -> table back to 8'h12 (3'b011 -> 1), out_valid=0, cfg_busy=0.
- Build without TT_CFG_EN, drive a full 8'h80 load -> cfg_done never pulses; function stays 8'h12.
